// File: rtl/shifter_pipe_pkg.sv
// Shared opcode encodings and elaboration-time configuration check for the
// pipelined barrel shifter.
package shifter_pkg;

   localparam logic [2:0] OP_ROL = 3'b000;
   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_ROR = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_SRA = 3'b100;

   // Width must be a power of two >= 4 with one pipeline stage per shift-amount bit.
   function automatic bit shamt_width_ok(input int operand_width, input int shamt_width);
      return (operand_width >= 4) &&
             ((operand_width & (operand_width - 1)) == 0) &&
             (shamt_width == $clog2(operand_width));
   endfunction

endpackage

// File: rtl/shifter_pipe_if.sv
// Valid/ready operation and result channels of the pipelined shifter.
// The slave modport is the shifter; the master modport is its producer/consumer.
interface shifter_pipe_if #(
   parameter int OPERAND_WIDTH  = 16,
   parameter int SHAMT_WIDTH    = 4,
   parameter int NUM_OPERATIONS = 3,
   parameter int TAG_WIDTH      = 4
);

   logic                      in_valid;
   logic                      in_ready;
   logic [OPERAND_WIDTH-1:0]  In;
   logic [SHAMT_WIDTH-1:0]    ShAmt;
   logic [NUM_OPERATIONS-1:0] Oper;
   logic [TAG_WIDTH-1:0]      in_tag;
   logic                      out_valid;
   logic                      out_ready;
   logic [OPERAND_WIDTH-1:0]  Out;
   logic [TAG_WIDTH-1:0]      out_tag;

   modport master (
      output in_valid, In, ShAmt, Oper, in_tag, out_ready,
      input  in_ready, out_valid, Out, out_tag
   );

   modport slave (
      input  in_valid, In, ShAmt, Oper, in_tag, out_ready,
      output in_ready, out_valid, Out, out_tag
   );

endinterface

// File: rtl/shifter_pipe_stage.sv
// One pipeline stage: conditionally shifts by 2**STAGE according to its own
// shift-amount bit, then registers data, sideband and valid under a hold enable.
module shifter_stage #(
   parameter int OPERAND_WIDTH  = 16,
   parameter int SHAMT_WIDTH    = 4,
   parameter int NUM_OPERATIONS = 3,
   parameter int TAG_WIDTH      = 4,
   parameter int STAGE          = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      advance,
   input  logic                      vld_prev,
   input  logic [OPERAND_WIDTH-1:0]  data_prev,
   input  logic [SHAMT_WIDTH-1:0]    shamt_prev,
   input  logic [NUM_OPERATIONS-1:0] oper_prev,
   input  logic [TAG_WIDTH-1:0]      tag_prev,
   output logic                      vld,
   output logic [OPERAND_WIDTH-1:0]  data,
   output logic [SHAMT_WIDTH-1:0]    shamt,
   output logic [NUM_OPERATIONS-1:0] oper,
   output logic [TAG_WIDTH-1:0]      tag
);
   import shifter_pkg::*;

   localparam int SHIFT = 1 << STAGE;

   localparam logic [NUM_OPERATIONS-1:0] ROL = NUM_OPERATIONS'(OP_ROL);
   localparam logic [NUM_OPERATIONS-1:0] SLL = NUM_OPERATIONS'(OP_SLL);
   localparam logic [NUM_OPERATIONS-1:0] ROR = NUM_OPERATIONS'(OP_ROR);
   localparam logic [NUM_OPERATIONS-1:0] SRL = NUM_OPERATIONS'(OP_SRL);
   localparam logic [NUM_OPERATIONS-1:0] SRA = NUM_OPERATIONS'(OP_SRA);

   logic signed [OPERAND_WIDTH-1:0] data_s;
   logic        [OPERAND_WIDTH-1:0] shifted;

   assign data_s = data_prev;

   // Reserved opcodes fall into the default arm and pass the operand through.
   always_comb begin
      shifted = data_prev;
      if (shamt_prev[STAGE]) begin
         case (oper_prev)
            ROL:     shifted = {data_prev[OPERAND_WIDTH-SHIFT-1:0],
                                data_prev[OPERAND_WIDTH-1:OPERAND_WIDTH-SHIFT]};
            SLL:     shifted = data_prev << SHIFT;
            ROR:     shifted = {data_prev[SHIFT-1:0],
                                data_prev[OPERAND_WIDTH-1:SHIFT]};
            SRL:     shifted = data_prev >> SHIFT;
            SRA:     shifted = data_s >>> SHIFT;
            default: shifted = data_prev;
         endcase
      end
   end

   // ---- stage register boundary ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld   <= 1'b0;
         data  <= '0;
         shamt <= '0;
         oper  <= '0;
         tag   <= '0;
      end else if (advance) begin
         vld   <= vld_prev;
         data  <= shifted;
         shamt <= shamt_prev;
         oper  <= oper_prev;
         tag   <= tag_prev;
      end
   end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one shift-amount bit resolved per registered stage,
// global-stall valid/ready flow control, one operation per cycle.
module shifter_pipe #(
   parameter int OPERAND_WIDTH  = 16,
   parameter int SHAMT_WIDTH    = 4,
   parameter int NUM_OPERATIONS = 3,
   parameter int TAG_WIDTH      = 4
) (
   input logic           clk,
   input logic           rst,
   shifter_pipe_if.slave bus
);
   import shifter_pkg::*;

   if (!shamt_width_ok(OPERAND_WIDTH, SHAMT_WIDTH)) begin : g_bad_cfg
      $error("shifter_pipe: OPERAND_WIDTH must be a power of two >= 4 and SHAMT_WIDTH its log2");
   end

   // Element k feeds stage k; element SHAMT_WIDTH is the final register set.
   logic                      vld_p   [0:SHAMT_WIDTH];
   logic [OPERAND_WIDTH-1:0]  data_p  [0:SHAMT_WIDTH];
   logic [SHAMT_WIDTH-1:0]    shamt_p [0:SHAMT_WIDTH];
   logic [NUM_OPERATIONS-1:0] oper_p  [0:SHAMT_WIDTH];
   logic [TAG_WIDTH-1:0]      tag_p   [0:SHAMT_WIDTH];

   logic advance;
   logic unused_tail;

   // Whole pipe moves together unless a finished result is being held back.
   assign advance      = !vld_p[SHAMT_WIDTH] || bus.out_ready;
   assign bus.in_ready = advance;

   assign vld_p[0]   = bus.in_valid && advance;
   assign data_p[0]  = bus.In;
   assign shamt_p[0] = bus.ShAmt;
   assign oper_p[0]  = bus.Oper;
   assign tag_p[0]   = bus.in_tag;

   for (genvar k = 0; k < SHAMT_WIDTH; k++) begin : g_stage
      shifter_stage #(
         .OPERAND_WIDTH  (OPERAND_WIDTH),
         .SHAMT_WIDTH    (SHAMT_WIDTH),
         .NUM_OPERATIONS (NUM_OPERATIONS),
         .TAG_WIDTH      (TAG_WIDTH),
         .STAGE          (k)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .advance    (advance),
         .vld_prev   (vld_p[k]),
         .data_prev  (data_p[k]),
         .shamt_prev (shamt_p[k]),
         .oper_prev  (oper_p[k]),
         .tag_prev   (tag_p[k]),
         .vld        (vld_p[k+1]),
         .data       (data_p[k+1]),
         .shamt      (shamt_p[k+1]),
         .oper       (oper_p[k+1]),
         .tag        (tag_p[k+1])
      );
   end

   assign bus.out_valid = vld_p[SHAMT_WIDTH];
   assign bus.Out       = data_p[SHAMT_WIDTH];
   assign bus.out_tag   = tag_p[SHAMT_WIDTH];

   // Shift amount and opcode are spent by the time they leave the last stage.
   assign unused_tail = ^{shamt_p[SHAMT_WIDTH], oper_p[SHAMT_WIDTH]};

endmodule
